// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the key debouncer bank.
// Build option: DEBOUNCE_LONGPRESS_EN adds a per-channel long-press strobe.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_LONG_CYCLES     = 50000000;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Long counter must also hold the saturated value n itself.
  function automatic int unsigned long_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, STABLE/CHECK FSM, strobes.
// With DEBOUNCE_LONGPRESS_EN a saturating long-press counter is added.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef DEBOUNCE_LONGPRESS_EN
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
`endif
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
`ifdef DEBOUNCE_LONGPRESS_EN
  output logic key_long,
`endif
  output logic key_release
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_LVL = ACTIVE_LOW;

  logic sync1_q, sync2_q;
  logic s;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_q, out_d;
  logic press_q, press_d;
  logic rel_q, rel_d;

  assign s = sync2_q ^ REL_LVL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s != out_q) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (s == out_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          out_d   = s;
          press_d = s;
          rel_d   = ~s;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_out     = out_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int unsigned LW = long_w(LONG_CYCLES);
  localparam logic [LW-1:0] LSAT  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LFIRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic long_q, long_d;

  // Parks at LSAT after firing so a held key strobes only once.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (!out_q) begin
      lcnt_d = '0;
    end else if (lcnt_q == LFIRE) begin
      lcnt_d = LSAT;
      long_d = 1'b1;
    end else if (lcnt_q != LSAT) begin
      lcnt_d = lcnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_KEYS independent debounce channels with press/release strobes.
// Build option: DEBOUNCE_LONGPRESS_EN adds key_long and LONG_CYCLES use.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
`ifdef DEBOUNCE_LONGPRESS_EN
  output logic [N_KEYS-1:0] key_long,
`endif
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef DEBOUNCE_LONGPRESS_EN
      .LONG_CYCLES    (LONG_CYCLES),
`endif
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_out    (key_out[i]),
      .key_press  (key_press[i]),
`ifdef DEBOUNCE_LONGPRESS_EN
      .key_long   (key_long[i]),
`endif
      .key_release(key_release[i])
    );
  end

`ifndef DEBOUNCE_LONGPRESS_EN
  // Long-press length has no hardware in this build.
  logic unused_long;
  assign unused_long = (LONG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (4 keys, 8-cycle debounce, 20-cycle long).
// Long-press checks are active when DEBOUNCE_LONGPRESS_EN is defined.
module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_press;
  logic [3:0] key_release;
`ifdef DEBOUNCE_LONGPRESS_EN
  logic [3:0] key_long;
`endif

  int vectors;
  int miscompares;

  debounce_bank #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_out    (key_out),
    .key_press  (key_press),
`ifdef DEBOUNCE_LONGPRESS_EN
    .key_long   (key_long),
`endif
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run(
    input int         n,
    input logic [3:0] eo,
    input logic [3:0] ep,
    input logic [3:0] er,
    input logic [3:0] el,
    input string      tag
  );
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      assert (key_out === eo) else begin
        miscompares++;
        $error("FAIL %s[%0d] key_out obs=%h exp=%h", tag, i, key_out, eo);
      end
      vectors++;
      assert (key_press === ep) else begin
        miscompares++;
        $error("FAIL %s[%0d] key_press obs=%h exp=%h", tag, i, key_press, ep);
      end
      vectors++;
      assert (key_release === er) else begin
        miscompares++;
        $error("FAIL %s[%0d] key_release obs=%h exp=%h", tag, i, key_release, er);
      end
`ifdef DEBOUNCE_LONGPRESS_EN
      vectors++;
      assert (key_long === el) else begin
        miscompares++;
        $error("FAIL %s[%0d] key_long obs=%h exp=%h", tag, i, key_long, el);
      end
`else
      if (el !== 4'h0) $info("long expectation %h ignored", el);
`endif
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    key_in      = 4'hF;

    run(3, 4'h0, 4'h0, 4'h0, 4'h0, "reset");
    rst = 1'b0;
    run(3, 4'h0, 4'h0, 4'h0, 4'h0, "idle");

    // Clean press on key 0: strobe at E0+10.
    key_in = 4'hE;
    run(10, 4'h0, 4'h0, 4'h0, 4'h0, "press0_wait");
    run(1,  4'h1, 4'h1, 4'h0, 4'h0, "press0_edge");
    run(3,  4'h1, 4'h0, 4'h0, 4'h0, "press0_hold");

    // Five-cycle glitch on key 1 is rejected.
    key_in = 4'hC;
    run(5,  4'h1, 4'h0, 4'h0, 4'h0, "glitch1_low");
    key_in = 4'hE;
    run(12, 4'h1, 4'h0, 4'h0, 4'h0, "glitch1_after");

    // Key 2 bounces every 3 cycles, then settles pressed.
    for (int b = 0; b < 6; b++) begin
      key_in[2] = b[0];
      run(3, 4'h1, 4'h0, 4'h0, 4'h0, "bounce2");
    end
    key_in[2] = 1'b0;
    run(10, 4'h1, 4'h0, 4'h0, 4'h0, "bounce2_wait");
    run(1,  4'h5, 4'h4, 4'h0, 4'h0, "bounce2_edge");
    run(3,  4'h5, 4'h0, 4'h0, 4'h0, "bounce2_hold");

    // Release key 0 and press key 3 on the same edge.
    key_in = 4'b0011;
    run(10, 4'h5, 4'h0, 4'h0, 4'h0, "simul_wait");
    run(1,  4'hC, 4'h8, 4'h1, 4'h0, "simul_edge");
    run(3,  4'hC, 4'h0, 4'h0, 4'h0, "simul_hold");

    // Reset while key 1 is mid-CHECK; keys stay held through reset.
    key_in = 4'b0001;
    run(5, 4'hC, 4'h0, 4'h0, 4'h0, "check1_mid");
    rst = 1'b1;
    run(3, 4'h0, 4'h0, 4'h0, 4'h0, "rst_mid");
    rst = 1'b0;
    run(10, 4'h0, 4'h0, 4'h0, 4'h0, "postrst_wait");
    run(1,  4'hE, 4'hE, 4'h0, 4'h0, "postrst_edge");

    // Keys 1-3 held: one long strobe 20 cycles after the press strobe.
    run(19, 4'hE, 4'h0, 4'h0, 4'h0, "long_wait");
    run(1,  4'hE, 4'h0, 4'h0, 4'hE, "long_edge");
    run(25, 4'hE, 4'h0, 4'h0, 4'h0, "long_once");

    key_in = 4'hF;
    run(10, 4'hE, 4'h0, 4'h0, 4'h0, "rel_all_wait");
    run(1,  4'h0, 4'h0, 4'hE, 4'h0, "rel_all_edge");
    run(3,  4'h0, 4'h0, 4'h0, 4'h0, "rel_all_idle");

    // Key 0 released 15 cycles after its press: no long strobe.
    key_in = 4'hE;
    run(10, 4'h0, 4'h0, 4'h0, 4'h0, "short0_wait");
    run(1,  4'h1, 4'h1, 4'h0, 4'h0, "short0_press");
    run(4,  4'h1, 4'h0, 4'h0, 4'h0, "short0_hold");
    key_in = 4'hF;
    run(10, 4'h1, 4'h0, 4'h0, 4'h0, "short0_relwait");
    run(1,  4'h0, 4'h0, 4'h1, 4'h0, "short0_rel");
    run(15, 4'h0, 4'h0, 4'h0, 4'h0, "short0_nolong");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
